// File: rtl/trace_pkg.sv
// ============================================================================
//  Module      : trace_pkg
//  Description : Shared types and constants for the commit trace buffer:
//                FSM state encoding, trace entry layout, ebreak opcode.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package trace_pkg;

    // Default datapath width used for the packed entry layout below
    localparam int TRACE_XLEN = 32;

    // ebreak encoding; seeing it on the commit bus halts capture
    localparam logic [31:0] EBREAK_INS = 32'h0010_0073;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TRIG = 2'd1,
        ST_CAPTURE   = 2'd2,
        ST_DRAIN     = 2'd3
    } trace_state_e;

    // Entry as stored in the trace RAM, most significant field first
    typedef struct packed {
        logic [TRACE_XLEN-1:0] pc;
        logic [4:0]            rd;
        logic [TRACE_XLEN-1:0] data;
    } trace_entry_t;

    localparam int TRACE_ENTRY_W = $bits(trace_entry_t);

endpackage

`default_nettype wire

// File: rtl/trace_ram.sv
// ============================================================================
//  Module      : trace_ram
//  Description : DEPTH x WIDTH storage, one synchronous write port and one
//                asynchronous read port. Contents are never cleared.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trace_ram #(
    parameter int WIDTH = 69,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: one entry per cycle when enabled
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port is combinational so the head entry is visible immediately
    assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/commit_trace_buffer.sv
// ============================================================================
//  Module      : commit_trace_buffer
//  Description : Captures register-writeback commits (PC, rd, data) into a
//                trace RAM with arming, optional PC trigger, linear or
//                circular capture, ebreak halt and a valid/ready drain port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [XLEN-1:0]          PC,
    input  logic [31:0]              INS,
    input  logic                     RegWEN,
    input  logic [4:0]               WRITE_REG,
    input  logic [XLEN-1:0]          REG_DATA_W,
    input  logic                     ARM,
    input  logic                     STOP,
    input  logic                     MODE,
    input  logic                     TRIG_EN,
    input  logic [XLEN-1:0]          TRIG_PC,
    output logic                     RD_VALID,
    input  logic                     RD_READY,
    output logic [XLEN-1:0]          RD_PC,
    output logic [4:0]               RD_REG,
    output logic [XLEN-1:0]          RD_DATA,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     OVERFLOW,
    output logic [1:0]               STATE
);

    localparam int             PW         = $clog2(DEPTH);
    localparam int             EW         = 2 * XLEN + 5;
    localparam logic [PW:0]    FULL_COUNT = (PW + 1)'(DEPTH);

    trace_state_e  state;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;
    logic          overflow;

    logic          commit;
    logic          halt;
    logic          trig_hit;
    logic          is_full;
    logic          capture_win;
    logic          push;
    logic          pop;
    logic          wr_en;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] rd_entry;

    // Event decode: what happens on the commit bus this cycle
    always_comb begin
        commit      = RegWEN && (WRITE_REG != 5'd0);
        halt        = STOP || (INS == EBREAK_INS);
        trig_hit    = (PC == TRIG_PC);
        is_full     = (count == FULL_COUNT);
        // The trigger-matching cycle itself is already part of the capture
        capture_win = (state == ST_CAPTURE) ||
                      ((state == ST_WAIT_TRIG) && trig_hit);
        // Linear mode never writes past full; circular overwrites the oldest
        push        = capture_win && commit && !(is_full && !MODE);
        pop         = (state == ST_DRAIN) && (count != '0) && RD_READY;
        wr_en       = push && !RST;
        wr_entry    = {PC, WRITE_REG, REG_DATA_W};
    end

    trace_ram #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_trace_ram (
        .clk     (CLK),
        .wr_en   (wr_en),
        .wr_addr (tail),
        .wr_data (wr_entry),
        .rd_addr (head),
        .rd_data (rd_entry)
    );

    // Session FSM with pointer, occupancy and overflow bookkeeping
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ARM) begin
                        state    <= TRIG_EN ? ST_WAIT_TRIG : ST_CAPTURE;
                        head     <= '0;
                        tail     <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                    end
                end

                ST_WAIT_TRIG, ST_CAPTURE: begin
                    if (push) begin
                        tail <= tail + 1'b1;
                        if (is_full) begin
                            head     <= head + 1'b1;
                            overflow <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    if (halt) begin
                        state <= ST_DRAIN;
                    end else if (!MODE && (is_full ||
                                 (push && (count == FULL_COUNT - 1'b1)))) begin
                        state <= ST_DRAIN;
                    end else if ((state == ST_WAIT_TRIG) && trig_hit) begin
                        state <= ST_CAPTURE;
                    end
                end

                ST_DRAIN: begin
                    if (count == '0) begin
                        state <= ST_IDLE;
                    end else if (pop) begin
                        head  <= head + 1'b1;
                        count <= count - 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    // Drain port shows the head entry whenever something is left to read
    always_comb begin
        RD_VALID                  = (state == ST_DRAIN) && (count != '0);
        {RD_PC, RD_REG, RD_DATA}  = rd_entry;
        COUNT                     = count;
        OVERFLOW                  = overflow;
        STATE                     = state;
    end

endmodule

`default_nettype wire

// File: tb/tb_commit_trace_buffer.sv
// ============================================================================
//  Module      : tb_commit_trace_buffer
//  Description : Self-checking bench for commit_trace_buffer (DEPTH=4) with a
//                queue-based reference model, directed scenarios and random
//                traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_commit_trace_buffer;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] EBK = 32'h0010_0073;

    logic            CLK = 1'b0;
    logic            RST;
    logic [XLEN-1:0] PC;
    logic [31:0]     INS;
    logic            RegWEN;
    logic [4:0]      WRITE_REG;
    logic [XLEN-1:0] REG_DATA_W;
    logic            ARM, STOP, MODE, TRIG_EN;
    logic [XLEN-1:0] TRIG_PC;
    logic            RD_VALID, RD_READY;
    logic [XLEN-1:0] RD_PC, RD_DATA;
    logic [4:0]      RD_REG;
    logic [CW-1:0]   COUNT;
    logic            OVERFLOW;
    logic [1:0]      STATE;

    commit_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .PC(PC), .INS(INS), .RegWEN(RegWEN),
        .WRITE_REG(WRITE_REG), .REG_DATA_W(REG_DATA_W), .ARM(ARM),
        .STOP(STOP), .MODE(MODE), .TRIG_EN(TRIG_EN), .TRIG_PC(TRIG_PC),
        .RD_VALID(RD_VALID), .RD_READY(RD_READY), .RD_PC(RD_PC),
        .RD_REG(RD_REG), .RD_DATA(RD_DATA), .COUNT(COUNT),
        .OVERFLOW(OVERFLOW), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: session phase plus a queue of held entries
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    int   m_st = 0;     // 0 idle, 1 wait-trigger, 2 capture, 3 drain
    bit   m_ov = 0;
    ent_t q[$];
    ent_t popped[$];

    task automatic model_step();
        ent_t e;
        bit   hit, halt, is_commit;
        if (RST) begin
            m_st = 0; m_ov = 0; q.delete();
            return;
        end
        case (m_st)
            0: if (ARM) begin
                m_st = TRIG_EN ? 1 : 2; m_ov = 0; q.delete();
            end
            1, 2: begin
                hit       = (m_st == 2) || (PC == TRIG_PC);
                halt      = STOP || (INS == EBK);
                is_commit = RegWEN && (WRITE_REG != 0);
                if (hit && is_commit && !(q.size() == DEPTH && !MODE)) begin
                    e.pc = PC; e.rd = WRITE_REG; e.data = REG_DATA_W;
                    if (q.size() == DEPTH) begin
                        void'(q.pop_front());
                        m_ov = 1;
                    end
                    q.push_back(e);
                end
                if (halt)                               m_st = 3;
                else if (!MODE && q.size() == DEPTH)    m_st = 3;
                else if (m_st == 1 && hit)              m_st = 2;
            end
            default: begin
                if (q.size() == 0) m_st = 0;
                else if (RD_READY) popped.push_back(q.pop_front());
            end
        endcase
    endtask

    // One clock: advance model, clock the DUT, compare away from the edge
    task automatic tick();
        bit exp_valid;
        model_step();
        @(posedge CLK);
        #1;
        exp_valid = (m_st == 3) && (q.size() != 0);
        check("state",    64'(STATE),    64'(m_st));
        check("count",    64'(COUNT),    64'(q.size()));
        check("overflow", 64'(OVERFLOW), 64'(m_ov));
        check("rd_valid", 64'(RD_VALID), 64'(exp_valid));
        if (exp_valid) begin
            check("rd_pc",   64'(RD_PC),   64'(q[0].pc));
            check("rd_reg",  64'(RD_REG),  64'(q[0].rd));
            check("rd_data", 64'(RD_DATA), 64'(q[0].data));
        end
    endtask

    task automatic quiet();
        RST = 0; PC = '0; INS = NOP; RegWEN = 0; WRITE_REG = '0;
        REG_DATA_W = '0; ARM = 0; STOP = 0; RD_READY = 0;
    endtask

    task automatic arm(input bit mode, input bit trig_en, input logic [31:0] tpc);
        MODE = mode; TRIG_EN = trig_en; TRIG_PC = tpc;
        ARM = 1; tick(); ARM = 0;
    endtask

    task automatic commit(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] d);
        PC = pc; WRITE_REG = rd; REG_DATA_W = d; RegWEN = 1;
        tick();
        RegWEN = 0; WRITE_REG = '0;
    endtask

    task automatic stop();
        STOP = 1; tick(); STOP = 0;
    endtask

    // Drain to IDLE; pattern 1 uses ready = 1,0,0,1 repeating
    task automatic drain(input bit pattern);
        int k = 0;
        while (m_st != 0 && k < 40) begin
            RD_READY = pattern ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            tick();
            k++;
        end
        RD_READY = 0;
        check("drain_done", 64'(k < 40), 64'd1);
    endtask

    logic [31:0] held_data;

    initial begin
        quiet(); MODE = 0; TRIG_EN = 0; TRIG_PC = '0;

        // Reset state
        RST = 1; tick(); tick(); RST = 0;
        check("rst_valid", 64'(RD_VALID), 64'd0);

        // Linear: DRAIN after 4th commit, x1..x4 out in order
        arm(0, 0, '0);
        for (int i = 1; i <= 6; i++) commit(32'(4 * (i - 1)), 5'(i), 32'(8'h11 * i));
        check("lin_state", 64'(STATE), 64'd3);
        check("lin_ovf", 64'(OVERFLOW), 64'd0);
        popped.delete();
        drain(0);
        check("lin_npop", 64'(popped.size()), 64'd4);
        for (int i = 0; i < popped.size(); i++) begin
            check("lin_rd", 64'(popped[i].rd), 64'(i + 1));
            check("lin_data", 64'(popped[i].data), 64'(8'h11 * (i + 1)));
        end

        // Circular: oldest two overwritten, x3..x6 remain
        arm(1, 0, '0);
        for (int i = 1; i <= 6; i++) commit(32'(4 * (i - 1)), 5'(i), 32'(8'h11 * i));
        stop();
        check("circ_ovf", 64'(OVERFLOW), 64'd1);
        check("circ_count", 64'(COUNT), 64'd4);
        popped.delete();
        drain(0);
        check("circ_npop", 64'(popped.size()), 64'd4);
        for (int i = 0; i < popped.size(); i++)
            check("circ_rd", 64'(popped[i].rd), 64'(i + 3));

        // Trigger at PC 0x10
        arm(1, 1, 32'h10);
        for (int pc = 0; pc <= 'h18; pc += 4) commit(32'(pc), 5'(pc / 4 + 1), 32'(pc + 'h100));
        stop();
        popped.delete();
        drain(0);
        check("trig_npop", 64'(popped.size()), 64'd3);
        for (int i = 0; i < popped.size(); i++)
            check("trig_pc", 64'(popped[i].pc), 64'(32'h10 + 4 * i));

        // Filtering and ebreak halt
        arm(1, 0, '0);
        commit(32'h100, 5'd5, 32'hAA);
        commit(32'h104, 5'd0, 32'hDEAD);
        PC = 32'h108; WRITE_REG = 5'd7; REG_DATA_W = 32'hBEEF; RegWEN = 0; tick();
        commit(32'h10C, 5'd6, 32'hBB);
        INS = EBK; tick(); INS = NOP;
        check("halt_state", 64'(STATE), 64'd3);
        check("halt_count", 64'(COUNT), 64'd2);
        popped.delete();
        drain(0);
        check("filt_npop", 64'(popped.size()), 64'd2);
        if (popped.size() == 2) begin
            check("filt_rd0", 64'(popped[0].rd), 64'd5);
            check("filt_rd1", 64'(popped[1].rd), 64'd6);
        end

        // Backpressure: outputs held while stalled
        arm(0, 0, '0);
        for (int i = 1; i <= 4; i++) commit(32'(i * 16), 5'(i + 8), $urandom);
        tick();
        held_data = RD_DATA;
        RD_READY = 0; tick(); tick();
        check("bp_hold", 64'(RD_DATA), 64'(held_data));
        popped.delete();
        drain(1);
        check("bp_npop", 64'(popped.size()), 64'd4);
        for (int i = 0; i < popped.size(); i++)
            check("bp_rd", 64'(popped[i].rd), 64'(i + 9));

        // Reset mid-capture with three entries held
        arm(1, 0, '0);
        for (int i = 1; i <= 3; i++) commit(32'(i * 4), 5'(i), 32'(i));
        check("mid_count", 64'(COUNT), 64'd3);
        RST = 1; tick(); RST = 0;
        check("mid_state", 64'(STATE), 64'd0);
        check("mid_cnt0", 64'(COUNT), 64'd0);
        check("mid_valid", 64'(RD_VALID), 64'd0);

        // ARM while draining is ignored
        arm(1, 0, '0);
        commit(32'h20, 5'd3, 32'h33);
        commit(32'h24, 5'd4, 32'h44);
        stop();
        ARM = 1; tick(); tick(); ARM = 0;
        check("arm_drain_state", 64'(STATE), 64'd3);
        check("arm_drain_count", 64'(COUNT), 64'd2);
        drain(0);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            RST        = ($urandom_range(99) == 0);
            ARM        = ($urandom_range(7) == 0);
            STOP       = ($urandom_range(24) == 0);
            INS        = ($urandom_range(39) == 0) ? EBK : NOP;
            MODE       = 1'($urandom_range(1));
            TRIG_EN    = 1'($urandom_range(1));
            TRIG_PC    = 32'h40;
            PC         = 32'($urandom_range(31)) << 2;
            RegWEN     = ($urandom_range(3) != 0);
            WRITE_REG  = 5'($urandom_range(7));
            REG_DATA_W = $urandom;
            RD_READY   = 1'($urandom_range(1));
            tick();
        end
        quiet();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

Parametrised capture buffer that records register-writeback commits of the single-cycle RISC-V datapath (PC, destination register, write data) into an on-chip trace memory and drains them through a valid/ready read port. It sits beside `DATAPATH`, snooping its PC, instruction and writeback signals; it is the synthesizable successor to bench-only waveform inspection. It adds arming, optional PC trigger, linear or circular capture, `ebreak` halt detection and overflow reporting.

## Interface
- `XLEN`, 32, data/PC width.
- `DEPTH`, 16, trace entries; power of two, ≥2.
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `PC` in XLEN: PC of the instruction committing this cycle.
- `INS` in 32: instruction committing this cycle.
- `RegWEN` in 1: register-file write enable.
- `WRITE_REG` in 5: destination register.
- `REG_DATA_W` in XLEN: writeback data.
- `ARM` in 1: start a capture session; honoured only in IDLE.
- `STOP` in 1: end capture, go to DRAIN.
- `MODE` in 1: 0 = linear (stop when full), 1 = circular (overwrite oldest).
- `TRIG_EN` in 1: wait for `PC == TRIG_PC` before capturing.
- `TRIG_PC` in XLEN: trigger address.
- `RD_VALID` out 1, `RD_READY` in 1: drain handshake.
- `RD_PC` out XLEN, `RD_REG` out 5, `RD_DATA` out XLEN: head entry.
- `COUNT` out $clog2(DEPTH)+1: entries held.
- `OVERFLOW` out 1: sticky; an entry was overwritten in circular mode.
- `STATE` out 2: IDLE=0, WAIT_TRIG=1, CAPTURE=2, DRAIN=3.

## Operation
- Commit event: `RegWEN && WRITE_REG != 0`; entry = {PC, WRITE_REG, REG_DATA_W}.
- IDLE: on `ARM`, go to WAIT_TRIG if `TRIG_EN`, else CAPTURE. Clears `COUNT`, pointers and `OVERFLOW` on that edge.
- WAIT_TRIG: when `PC == TRIG_PC`, go to CAPTURE. The matching cycle's commit event is captured.
- CAPTURE: push every commit event.
  - MODE 0: when the push makes `COUNT == DEPTH`, go to DRAIN. No further pushes.
  - MODE 1, full: write at tail, advance head, `COUNT` stays `DEPTH`, set `OVERFLOW`.
- Leaving CAPTURE/WAIT_TRIG: `STOP` or `INS == 32'h00100073` (ebreak) goes to DRAIN. A commit in the same cycle is still captured. The ebreak itself writes no register.
- DRAIN:
  - `RD_VALID = (COUNT != 0)`; `RD_*` show the head entry (show-ahead).
  - Pop on `RD_VALID && RD_READY`.
  - When `COUNT == 0`, go to IDLE.
  - Entering DRAIN with `COUNT == 0` goes to IDLE the next cycle.
- `ARM` outside IDLE is ignored. `STOP` in IDLE/DRAIN is ignored. No pushes occur in DRAIN or IDLE.
- Pointer arithmetic is modulo `DEPTH` (natural wrap of $clog2(DEPTH)-bit pointers).

## Timing
- Reset values: STATE=IDLE, COUNT=0, OVERFLOW=0, RD_VALID=0, pointers 0. `RD_PC`/`RD_REG`/`RD_DATA` are don't-care while `RD_VALID=0`; the RAM is not cleared.
- `RST` mid-session aborts capture or drain immediately; buffer contents are discarded.
- Push latency: an entry written at edge N is counted in `COUNT` after edge N.
- The first `RD_VALID` is the cycle after entering DRAIN.
- `RD_*` are combinational from the head pointer and are stable while `RD_VALID && !RD_READY`.
- Throughput: one pop per cycle with `RD_READY` held high.
- Trigger compare is combinational on `PC` in the current cycle; there is no pipeline delay.

## Structure
- `trace_pkg`: `trace_state_e` enum, `trace_entry_t` struct {pc, rd, data} parametrised via XLEN localparam, and `EBREAK_INS` constant.
- Sub-module `trace_ram`: DEPTH × entry, one synchronous write port, one asynchronous read port.
- Top level holds the FSM, pointers, count and overflow.

## Test plan
- Linear, DEPTH=4, no trigger: ARM, then 6 commits x1..x6 with data 0x11..0x66 → DRAIN after the 4th; drain yields x1..x4 in order; OVERFLOW=0; IDLE after the 4th pop.
- Circular, DEPTH=4: 6 commits then STOP → drain yields x3..x6; OVERFLOW=1; COUNT goes 4→0.
- Trigger: TRIG_PC=0x0000_0010, commits at PCs 0x0,0x4,…,0x18 → entries for PCs 0x10, 0x14, 0x18 only.
- Filtering and halt: commits with WRITE_REG=0 and RegWEN=0 → not captured; INS=0x00100073 → DRAIN the next cycle with prior entries intact.
- Backpressure: RD_READY toggles 1,0,0,1 → RD_* held constant while stalled; no duplicate or lost entries.
- Reset mid-CAPTURE with COUNT=3 → next cycle STATE=IDLE, COUNT=0, RD_VALID=0; ARM while in DRAIN is ignored.
